// File: rtl/or_fscan_pkg.sv
// rtl/or_fscan_pkg.sv - shared types, fault codes, vector table and flag decode for the OR fault scanner
package or_fscan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_REPORT
    } state_t;

    localparam logic [2:0] FC_OK      = 3'd0;
    localparam logic [2:0] FC_SA1_ANY = 3'd1;
    localparam logic [2:0] FC_B_SA0   = 3'd2;
    localparam logic [2:0] FC_A_SA0   = 3'd3;
    localparam logic [2:0] FC_MULTI   = 3'd4;

    // Vector i lives at bits [2i+1:2i], encoded as {A,B}.
    localparam logic [7:0] VEC_TABLE = {2'b11, 2'b10, 2'b01, 2'b00};

    function automatic logic [1:0] vec_at(input logic [1:0] idx);
        return VEC_TABLE[{idx, 1'b0} +: 2];
    endfunction

    function automatic logic [2:0] decode_flags(input logic [3:0] flags);
        case (flags)
            4'b0000: return FC_OK;
            4'b0001: return FC_SA1_ANY;
            4'b0010: return FC_B_SA0;
            4'b0100: return FC_A_SA0;
            default: return FC_MULTI;
        endcase
    endfunction

endpackage

// File: rtl/or_fscan_settle_cnt.sv
// rtl/or_fscan_settle_cnt.sv - 8-bit settle countdown for the OR fault scanner
// Ports: clk, rst (async active-high), load/load_val (preset count),
//        en (decrement while nonzero), expired (count has reached zero).
module or_fscan_settle_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] load_val,
    output logic       expired
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign expired = (count == 8'd0);

endmodule

// File: rtl/or_fault_scanner.sv
// rtl/or_fault_scanner.sv - applies the four OR truth-table vectors to an external gate and classifies faults
// Ports: clk, rst (async active-high), start (scan request, sampled in IDLE),
//        dut_a/dut_b (registered gate drive), dut_z (gate output), busy, done (one-cycle pulse),
//        fault_flags (per-vector mismatch), fault_code (classification).
// Optional: OR_FSCAN_CONTINUOUS_EN lets REPORT restart a scan directly while start is held.
module or_fault_scanner
    import or_fscan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_z,
    output logic       busy,
    output logic       done,
    output logic [3:0] fault_flags,
    output logic [2:0] fault_code
);

    localparam logic [7:0] SETTLE_LOAD  = 8'(SETTLE_CYCLES - 1);
    // On a continuous restart the REPORT cycle already holds vector 0 (00),
    // so it counts as the first settle cycle of the new scan.
    localparam logic [7:0] RESTART_LOAD = (SETTLE_CYCLES > 1) ? 8'(SETTLE_CYCLES - 2) : 8'd0;

    state_t     state, next_state;
    logic [1:0] idx;
    logic       cnt_load, cnt_en, cnt_expired;
    logic [7:0] load_val;
    logic       restart;
    logic       expected, mismatch;
    logic [3:0] flags_next;

    or_fscan_settle_cnt u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (load_val),
        .expired  (cnt_expired)
    );

    assign expected   = |vec_at(idx);
    // Case inequality so an X or Z from the gate is flagged.
    assign mismatch   = (dut_z !== expected);
    assign flags_next = fault_flags | (mismatch ? 4'(4'b0001 << idx) : 4'b0000);

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        load_val   = SETTLE_LOAD;
        restart    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_SETTLE;
                    cnt_load   = 1'b1;
                    restart    = 1'b1;
                end
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (cnt_expired) begin
                    next_state = ST_SAMPLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_SAMPLE: begin
                busy     = 1'b1;
                cnt_load = 1'b1;
                if (idx == 2'd3) begin
                    next_state = ST_REPORT;
                end else begin
                    next_state = ST_SETTLE;
                end
            end
            ST_REPORT: begin
                done       = 1'b1;
                next_state = ST_IDLE;
`ifdef OR_FSCAN_CONTINUOUS_EN
                if (start) begin
                    busy       = 1'b1;
                    restart    = 1'b1;
                    cnt_load   = 1'b1;
                    load_val   = RESTART_LOAD;
                    next_state = (SETTLE_CYCLES > 1) ? ST_SETTLE : ST_SAMPLE;
                end
`endif
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= 2'd0;
            dut_a       <= 1'b0;
            dut_b       <= 1'b0;
            fault_flags <= 4'b0000;
            fault_code  <= FC_OK;
        end else begin
            state <= next_state;
            if (restart) begin
                idx            <= 2'd0;
                {dut_a, dut_b} <= vec_at(2'd0);
                fault_flags    <= 4'b0000;
                fault_code     <= FC_OK;
            end else if (state == ST_SAMPLE) begin
                fault_flags <= flags_next;
                if (idx == 2'd3) begin
                    fault_code <= decode_flags(flags_next);
                end
                // Index wraps 3 -> 0, which also parks the drive at 00 for REPORT/IDLE.
                idx            <= idx + 2'd1;
                {dut_a, dut_b} <= vec_at(idx + 2'd1);
            end
        end
    end

endmodule

// File: tb/tb_or_fault_scanner.sv
// tb/tb_or_fault_scanner.sv - directed scoreboard bench for or_fault_scanner
module tb_or_fault_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       dut_z;
    logic       dut_a, dut_b, busy, done;
    logic [3:0] fault_flags;
    logic [2:0] fault_code;
    int         mode = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [3:0] flags;
        logic [2:0] code;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Gate models: 0 ideal OR, 1 Z stuck-0, 2 Z=A, 3 Z=B, 4 Z stuck-1, 5 ideal but X on vector 3.
    always_comb begin
        case (mode)
            1:       dut_z = 1'b0;
            2:       dut_z = dut_a;
            3:       dut_z = dut_b;
            4:       dut_z = 1'b1;
            5:       dut_z = (dut_a & dut_b) ? 1'bx : (dut_a | dut_b);
            default: dut_z = dut_a | dut_b;
        endcase
    end

    or_fault_scanner #(.SETTLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dut_a       (dut_a),
        .dut_b       (dut_b),
        .dut_z       (dut_z),
        .busy        (busy),
        .done        (done),
        .fault_flags (fault_flags),
        .fault_code  (fault_code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_flags"}, {28'd0, fault_flags}, {28'd0, e.flags});
            check({tag, "_code"}, {29'd0, fault_code}, {29'd0, e.code});
        end
    endtask

    // Called near a negedge with the DUT in IDLE; the next posedge is cycle 0.
    task automatic scan(input string tag, input int m, input logic [3:0] ef,
                        input logic [2:0] ec, input bit hold);
        int dc;
        int gaps;
        dc   = 0;
        gaps = 0;
        mode = m;
        sb.push_back('{flags: ef, code: ec});
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int c = 1; c <= 40 && dc == 0; c++) begin
            @(negedge clk);
            if (done) dc = c;
            else if (!busy) gaps++;
        end
        check({tag, "_done_cycle"}, dc, 32'd21);
        check({tag, "_busy_window"}, gaps, 32'd0);
        pop_compare(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, {25'd0, fault_flags, fault_code}, {25'd0, ef, ec});
    endtask

    initial begin
        #1;
        check("reset_outputs", {21'd0, dut_a, dut_b, busy, done, fault_flags, fault_code}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Start on the first edge after reset release.
        scan("good", 0, 4'b0000, 3'd0, 1'b0);
        scan("z_sa0", 1, 4'b1110, 3'd4, 1'b0);
        scan("z_eq_a", 2, 4'b0010, 3'd2, 1'b0);
        scan("z_eq_b", 3, 4'b0100, 3'd3, 1'b0);
        scan("z_sa1", 4, 4'b0001, 3'd1, 1'b0);
        scan("z_x_v3", 5, 4'b1000, 3'd4, 1'b0);

        // Reset abort on cycle 9 of a stuck-at-1 scan.
        mode  = 4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_partial_flags", {28'd0, fault_flags}, 32'h1);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_outputs", {21'd0, dut_a, dut_b, busy, done, fault_flags, fault_code}, 32'd0);
        @(negedge clk);
        check("abort_held", {21'd0, dut_a, dut_b, busy, done, fault_flags, fault_code}, 32'd0);
        rst = 1'b0;
        scan("after_abort", 0, 4'b0000, 3'd0, 1'b0);

`ifndef OR_FSCAN_CONTINUOUS_EN
        // Start held through the scan: no restart until IDLE is reached.
        scan("hold", 0, 4'b0000, 3'd0, 1'b1);
        check("hold_idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("hold_restart_busy", {31'd0, busy}, 32'd1);
        check("hold_restart_flags_clear", {28'd0, fault_flags}, 32'd0);
        start = 1'b0;
        sb.push_back('{flags: 4'b0000, code: 3'd0});
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 40 && seen == 0; c++) begin
                @(negedge clk);
                if (done) seen = c + 2;
            end
            check("hold_second_done_cycle", seen, 32'd21);
            pop_compare("hold_second");
        end
        @(negedge clk);
`else
        begin
            int dcs[$];
            int gaps;
            gaps  = 0;
            mode  = 0;
            start = 1'b1;
            repeat (3) sb.push_back('{flags: 4'b0000, code: 3'd0});
            @(posedge clk);
            for (int c = 1; c <= 61; c++) begin
                @(negedge clk);
                if (!busy) gaps++;
                if (done) begin
                    dcs.push_back(c);
                    pop_compare("cont");
                end
            end
            start = 1'b0;
            check("cont_done_count", dcs.size(), 32'd3);
            check("cont_busy_gaps", gaps, 32'd0);
            if (dcs.size() == 3) begin
                check("cont_done1", dcs[0], 32'd21);
                check("cont_done2", dcs[1], 32'd41);
                check("cont_done3", dcs[2], 32'd61);
            end
            repeat (25) @(negedge clk);
            check("cont_stop_busy", {31'd0, busy}, 32'd0);
        end
`endif

        check("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
